// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment display arbiter and its sequential
// binary-to-BCD converter: FSM state encoding, data widths, the display
// ceiling, and small combinational helpers used by both modules.
// -----------------------------------------------------------------------------
package seg7_pkg;

  localparam int BCD_W       = 4;
  localparam int BIN_W       = 14;
  localparam int MAX_VALUE   = 9999;
  localparam int CONV_CYCLES = 14;
  localparam int DWELL_W     = 27;

  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VALUE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SHOW = 2'd2
  } state_t;

  // Four BCD digits, most significant first so the packed value reads as the
  // decimal number when printed in hex.
  typedef struct packed {
    logic [BCD_W-1:0] thousands;
    logic [BCD_W-1:0] hundreds;
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd4_t;

  // Saturate a raw binary value to the largest number four digits can show.
  function automatic logic [BIN_W-1:0] clamp_bin(input logic [BIN_W-1:0] v);
    return (v > MAX_BIN) ? MAX_BIN : v;
  endfunction

  // Double-dabble correction: any digit of 5 or more gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic bcd4_t add3_all(input bcd4_t d);
    bcd4_t r;
    r = d;
    if (d.ones      >= 4'd5) r.ones      = d.ones      + 4'd3;
    if (d.tens      >= 4'd5) r.tens      = d.tens      + 4'd3;
    if (d.hundreds  >= 4'd5) r.hundreds  = d.hundreds  + 4'd3;
    if (d.thousands >= 4'd5) r.thousands = d.thousands + 4'd3;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-add-3 (double-dabble) converter, one bit per clock.
// A start pulse loads the value; 14 clocks later the four digit outputs are
// replaced in one step. Digits are never exposed mid-conversion and hold
// their value until the next conversion completes.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active high
//   start      in   load value and begin converting (ignored during reset)
//   value      in   14-bit binary value, expected <= 9999
//   done       out  high in the cycle whose closing edge commits the digits
//   ones..thousands out  BCD digits of the last completed conversion
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             done,
  output logic [BCD_W-1:0] ones,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] hundreds,
  output logic [BCD_W-1:0] thousands
);

  localparam logic [3:0] LAST_STEP = 4'(CONV_CYCLES - 1);

  logic [BIN_W-1:0] bin_q,    bin_d;
  bcd4_t            work_q,   work_d;
  logic [3:0]       step_q,   step_d;
  logic             active_q, active_d;
  bcd4_t            digits_q, digits_d;

  bcd4_t            work_adj;
  bcd4_t            work_shift;

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the if/else leaves it unassigned and infers a latch.
    bin_d    = bin_q;
    work_d   = work_q;
    step_d   = step_q;
    active_d = active_q;
    digits_d = digits_q;
    done     = 1'b0;

    work_adj   = add3_all(work_q);
    work_shift = {work_adj[4*BCD_W-2:0], bin_q[BIN_W-1]};

    if (start) begin
      bin_d    = value;
      work_d   = '0;
      step_d   = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      work_d = work_shift;
      bin_d  = {bin_q[BIN_W-2:0], 1'b0};
      step_d = step_q + 4'd1;
      if (step_q == LAST_STEP) begin
        // Final shift: publish the complete result directly, bypassing the
        // working register, so all four digits change on the same edge.
        active_d = 1'b0;
        digits_d = work_shift;
        done     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    if (rst_n) begin
      bin_q    <= '0;
      work_q   <= '0;
      step_q   <= '0;
      active_q <= 1'b0;
      digits_q <= '0;
    end else begin
      bin_q    <= bin_d;
      work_q   <= work_d;
      step_q   <= step_d;
      active_q <= active_d;
      digits_q <= digits_d;
    end
  end

  assign ones      = digits_q.ones;
  assign tens      = digits_q.tens;
  assign hundreds  = digits_q.hundreds;
  assign thousands = digits_q.thousands;

endmodule

// File: rtl/seg7_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg7_display_arbiter
// Lets two requesters share one four-digit seven-segment display. A winner is
// picked round-robin, its value is captured and clamped to 9999, converted to
// BCD over 14 cycles, and shown for DWELL_CYCLES cycles before the display is
// offered again. Requests arriving while busy wait (they are level signals).
//
// Ports
//   clk                  in   rising-edge clock
//   rst_n                in   synchronous reset, ACTIVE HIGH despite the name
//   req_a / req_b        in   level requests, held until granted
//   val_a / val_b        in   14-bit binary values, captured at grant
//   gnt_a / gnt_b        out  one-cycle grant pulses
//   ones..thousands      out  BCD digits for the display driver
//   ovf                  out  shown value was clamped to 9999
//   busy                 out  FSM is not IDLE
// -----------------------------------------------------------------------------
module seg7_display_arbiter
  import seg7_pkg::*;
#(
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [BIN_W-1:0] val_a,
  input  logic             req_b,
  input  logic [BIN_W-1:0] val_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic [BCD_W-1:0] ones,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] hundreds,
  output logic [BCD_W-1:0] thousands,
  output logic             ovf,
  output logic             busy
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  state_t             state_q,    state_d;
  logic               prefer_b_q, prefer_b_d;  // round-robin pointer
  logic               gnt_a_q,    gnt_a_d;
  logic               gnt_b_q,    gnt_b_d;
  logic               ovf_pend_q, ovf_pend_d;  // clamp flag of value in flight
  logic               ovf_q,      ovf_d;       // clamp flag of value on show
  logic [DWELL_W-1:0] dwell_q,    dwell_d;

  logic               pick_b;
  logic [BIN_W-1:0]   sel_val;
  logic               conv_start;
  logic [BIN_W-1:0]   conv_value;
  logic               conv_done;

  always_comb begin
    state_d    = state_q;
    prefer_b_d = prefer_b_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    dwell_d    = dwell_q;
    pick_b     = 1'b0;
    sel_val    = val_a;
    conv_start = 1'b0;
    conv_value = '0;

    unique case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          // B wins when alone, or when both ask and A was served last.
          pick_b     = req_b && (!req_a || prefer_b_q);
          sel_val    = pick_b ? val_b : val_a;
          gnt_a_d    = !pick_b;
          gnt_b_d    = pick_b;
          prefer_b_d = !pick_b;
          ovf_pend_d = (sel_val > MAX_BIN);
          conv_value = clamp_bin(sel_val);
          conv_start = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        // ovf is published on the same edge as the digits.
        if (conv_done) begin
          ovf_d   = ovf_pend_q;
          dwell_d = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (dwell_q == DWELL_LAST) begin
          state_d = IDLE;
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= IDLE;
      prefer_b_q <= 1'b0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      dwell_q    <= '0;
    end else begin
      state_q    <= state_d;
      prefer_b_q <= prefer_b_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      dwell_q    <= dwell_d;
    end
  end

  // The converter shares the reset, so a reset mid-conversion drops the
  // operation and clears the digits without ever committing a partial value.
  bin2bcd_seq u_bin2bcd (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (conv_start),
    .value     (conv_value),
    .done      (conv_done),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands)
  );

  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg7_display_arbiter
// Directed bench for seg7_display_arbiter with DWELL_CYCLES = 8. Stimulus
// pushes the expected grant/display outcome into a scoreboard queue; an
// independent monitor pops an entry on every grant and follows that display
// through conversion, show and return to idle (or through a reset abort).
// -----------------------------------------------------------------------------
module tb_seg7_display_arbiter;

  localparam int DWELL = 8;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [13:0] val_a = '0;
  logic [13:0] val_b = '0;
  logic        gnt_a, gnt_b, ovf, busy;
  logic [3:0]  ones, tens, hundreds, thousands;

  seg7_display_arbiter #(.DWELL_CYCLES(DWELL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .val_a     (val_a),
    .req_b     (req_b),
    .val_b     (val_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .ones      (ones),
    .tens      (tens),
    .hundreds  (hundreds),
    .thousands (thousands),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  wire [15:0] disp = {thousands, hundreds, tens, ones};

  typedef struct {
    bit          who_b;   // 1: expect gnt_b, 0: expect gnt_a
    logic [15:0] digits;  // expected BCD digits, thousands first
    bit          ovf;
    int          gap;     // expected cycles since previous grant, 0 = ignore
  } exp_t;

  exp_t        sb_q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int unsigned cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: grant at k=0 (cycle T+1); digits due at k=14 (T+15);
  // busy drops at k=22 (T+23). Reset sampled during the window ends it.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t        e;
    logic [16:0] prev;
    bit          held_ok;
    bit          aborted;
    logic        rst_prev;
    int unsigned last_gnt;
    bit          have_last;
    have_last = 0;
    last_gnt  = 0;
    forever begin
      @(negedge clk);
      if (gnt_a || gnt_b) begin
        check("gnt_exclusive", 32'(gnt_a & gnt_b), 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_gnt", 32'({gnt_a, gnt_b}), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("gnt_who_b", 32'(gnt_b), 32'(e.who_b));
          if (e.gap > 0 && have_last)
            check("gnt_gap", 32'(cyc - last_gnt), 32'(e.gap));
          last_gnt  = cyc;
          have_last = 1;
          prev      = {ovf, disp};
          held_ok   = 1;
          aborted   = 0;
          for (int k = 1; k <= 22 && !aborted; k++) begin
            rst_prev = rst_n;
            @(negedge clk);
            if (gnt_a || gnt_b) check("gnt_in_window", 32'(k), 32'd0);
            if (rst_prev) begin
              check("abort_digits", 32'(disp), 32'd0);
              check("abort_ovf",    32'(ovf),  32'd0);
              check("abort_busy",   32'(busy), 32'd0);
              aborted = 1;
            end else if (k < 14) begin
              if ({ovf, disp} !== prev) held_ok = 0;
            end else if (k == 14) begin
              check("digits_held_in_conv", 32'(held_ok), 32'd1);
              check("digits", 32'(disp), 32'(e.digits));
              check("ovf",    32'(ovf),  32'(e.ovf));
              check("busy_show_start", 32'(busy), 32'd1);
            end else if (k == 21) begin
              check("busy_show_end", 32'(busy), 32'd1);
            end else if (k == 22) begin
              check("busy_idle", 32'(busy), 32'd0);
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers; all input changes happen 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic push(input bit who_b, input logic [15:0] d, input bit o,
                      input int gap);
    exp_t e;
    e.who_b  = who_b;
    e.digits = d;
    e.ovf    = o;
    e.gap    = gap;
    sb_q.push_back(e);
  endtask

  task automatic wait_gnt(input bit who_b);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (who_b ? gnt_b : gnt_a) ok = 1;
    end
    if (!ok) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic request(input bit who_b, input logic [13:0] v,
                         input logic [15:0] d, input bit o, input int gap);
    push(who_b, d, o, gap);
    if (who_b) begin val_b = v; req_b = 1'b1; end
    else       begin val_a = v; req_a = 1'b1; end
    wait_gnt(who_b);
    if (who_b) req_b = 1'b0;
    else       req_a = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      if (!busy) ok = 1;
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    check("rst_digits", 32'(disp), 32'd0);
    check("rst_ovf",    32'(ovf),  32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_gnt",    32'({gnt_a, gnt_b}), 32'd0);

    // Basic conversion and timing.
    request(1'b0, 14'd1234, 16'h1234, 1'b0, 0);
    wait_idle();

    // Value changes after capture are ignored.
    push(1'b0, 16'h4321, 1'b0, 0);
    val_a = 14'd4321;
    req_a = 1'b1;
    wait_gnt(1'b0);
    req_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    val_a = 14'd1111;
    wait_idle();

    // Clamp, zero, and the exact ceiling.
    request(1'b1, 14'd12000, 16'h9999, 1'b1, 0);
    wait_idle();
    request(1'b1, 14'd0,     16'h0000, 1'b0, 0);
    wait_idle();
    request(1'b1, 14'd9999,  16'h9999, 1'b0, 0);
    wait_idle();

    // Reset in the middle of a conversion: display clears, 5678 never shows.
    request(1'b0, 14'd5678, 16'h0000, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    check("abort_now_digits", 32'(disp), 32'd0);
    check("abort_now_busy",   32'(busy), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_late_digits", 32'(disp), 32'd0);
    check("abort_stays_idle",     32'(busy), 32'd0);

    // Simultaneous requests: A first after reset, then alternate.
    push(1'b0, 16'h0100, 1'b0, 0);
    push(1'b1, 16'h2345, 1'b0, 23);
    push(1'b0, 16'h0100, 1'b0, 23);
    val_a = 14'd100;
    val_b = 14'd2345;
    req_a = 1'b1;
    req_b = 1'b1;
    wait_gnt(1'b0);
    wait_gnt(1'b1);
    wait_gnt(1'b0);
    req_a = 1'b0;
    req_b = 1'b0;
    wait_idle();

    // Request raised in SHOW cycle 2 waits for IDLE.
    request(1'b0, 14'd777, 16'h0777, 1'b0, 0);
    repeat (15) @(posedge clk);
    #1;
    request(1'b1, 14'd42, 16'h0042, 1'b0, 23);
    wait_idle();

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_display_arbiter.md
SEG7_DISPLAY_ARBITER -- requirements
Module: seg7_display_arbiter

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 100_000_000, giving the SHOW hold time in clk cycles (1 s at 100 MHz); legal range 1..2^27-1.
REQ-002 SHALL have the following ports, in this order:
- clk  input  1  sole clock, all logic on its rising edge.
- rst_n  input  1  reset; synchronous and active-high despite the name, matching codebase naming.
- req_a  input  1  requester A wants the display; level, held until granted.
- val_a  input  14  requester A binary value.
- req_b  input  1  requester B wants the display; level, held until granted.
- val_b  input  14  requester B binary value.
- gnt_a  output  1  one-cycle pulse: A granted, val_a captured.
- gnt_b  output  1  one-cycle pulse: B granted, val_b captured.
- ones, tens, hundreds, thousands  output  4 each  BCD digits feeding seg7_control.
- ovf  output  1  displayed value was clamped.
- busy  output  1  high whenever the state is not IDLE.

Function
REQ-003 SHALL implement the FSM IDLE -> CONV -> SHOW -> IDLE, with no other states.
REQ-004 In IDLE with any request sampled high at cycle T, SHALL select a winner, pulse its gnt at T+1, capture its value, and enter CONV at T+1.
REQ-005 Arbitration SHALL be round-robin with a one-bit last-winner pointer:
- single request: that requester wins.
- simultaneous requests: the requester not served last wins.
- pointer after reset: favours A.
REQ-006 A captured value greater than 9999 SHALL be clamped to 9999 and set ovf for that display; otherwise ovf SHALL be 0.
REQ-007 CONV SHALL run a sequential shift-add-3 binary-to-BCD conversion.
- duration: exactly 14 cycles (T+1..T+14).
- all four digit outputs and ovf update together at T+15; no intermediate values are ever visible.
REQ-008 SHOW SHALL last exactly DWELL_CYCLES cycles starting at T+15, then return to IDLE.
REQ-009 Requests seen in CONV or SHOW SHALL be neither granted nor lost; since req is level, they are arbitrated on the first IDLE cycle.
REQ-010 val_a/val_b changes after capture, and req deassertion after grant, SHALL have no effect on the conversion in progress.
REQ-011 Digit outputs and ovf SHALL hold their last value through IDLE and the next CONV.
REQ-012 gnt_a and gnt_b SHALL never be high in the same cycle, and each SHALL be at most one cycle wide.
REQ-013 A new display SHALL begin no sooner than 15+DWELL_CYCLES cycles after the previous grant.

Reset
REQ-014 When rst_n is sampled high, on that clock edge the block SHALL:
- set state to IDLE.
- clear gnt_a, gnt_b, busy and ovf to 0.
- set all digits to 0 (display "0000").
- set the pointer to favour A.
- clear the dwell counter and conversion registers.
REQ-015 Reset asserted during CONV or SHOW SHALL abort the operation with no partial digit update; the interrupted request is not remembered.
REQ-016 Requests SHALL be ignored in any cycle where rst_n is high.

Structure
REQ-017 Shared package seg7_pkg SHALL hold:
- the FSM state encoding.
- BCD_W=4, BIN_W=14, MAX_VALUE=9999, CONV_CYCLES=14.
REQ-018 The conversion SHALL be the sub-module bin2bcd_seq, with:
- ports: start pulse, 14-bit value, done pulse, four BCD digits.
- clock and reset shared with the parent.
REQ-019 The round-robin pointer and the dwell counter SHALL live in the top module; the dwell counter is 27 bits wide.

Verification (DWELL_CYCLES=8 unless stated)
REQ-020 Reset, then req_a=1 and val_a=1234 sampled at T -> gnt_a pulse at T+1; at T+15 thousands/hundreds/tens/ones=1/2/3/4 and ovf=0; busy falls at T+23.
REQ-021 Reset, then req_a and req_b high together at T -> gnt_a at T+1; gnt_b one cycle after IDLE is re-entered; with both still requesting, A is granted next.
REQ-022 val_b=12000 granted -> digits 9/9/9/9 with ovf=1; then val_b=0 -> digits 0/0/0/0 with ovf=0; val_b=9999 -> 9/9/9/9 with ovf=0.
REQ-023 rst_n pulsed high at T+5 of a CONV for val_a=5678 -> next cycle digits 0000, busy 0, no gnt; digits never show 5678.
REQ-024 req_b raised during SHOW cycle 2 -> no gnt_b until IDLE is re-entered, then gnt_b one cycle later.
REQ-025 val_a changed from 4321 to 1111 at T+3 of CONV -> digits 4/3/2/1 at T+15.
